// File: rtl/ball_motion.sv
// rtl/ball_motion.sv - ball kinematics: park on paddle, timed steps, reflections, death
// Optional feature macro: PADDLE_STEER_EN (paddle contact third selects the rebound direction)
module ball_motion #(
  parameter int MAX_X    = 79,
  parameter int MAX_Y    = 59,
  parameter int PADDLE_Y = 56,
  parameter int PADDLE_W = 12,
  parameter int XW       = 7,
  parameter int YW       = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [2:0]    state,
  input  logic [19:0]   period,
  input  logic [2:0]    angle,
  input  logic [XW-1:0] paddle_x,
  input  logic          brick_hit,
  output logic [XW-1:0] ball_x,
  output logic [YW-1:0] ball_y,
  output logic [XW-1:0] next_x,
  output logic [YW-1:0] next_y,
  output logic [2:0]    dir,
  output logic          step,
  output logic          dead
);

  localparam logic [XW-1:0]        MAX_X_C = XW'(MAX_X);
  localparam logic [YW-1:0]        MAX_Y_C = YW'(MAX_Y);
  localparam logic [YW-1:0]        PARK_Y  = YW'(PADDLE_Y - 1);
  localparam logic [XW-1:0]        HALF_W  = XW'(PADDLE_W / 2);
  localparam logic [XW:0]          PW      = (XW+1)'(PADDLE_W);
  localparam logic signed [XW:0]   X_ONE   = (XW+1)'(1);
  localparam logic signed [XW:0]   X_NEG   = -X_ONE;
  localparam logic signed [YW:0]   Y_ONE   = (YW+1)'(1);
  localparam logic signed [YW:0]   Y_NEG   = -Y_ONE;
`ifdef PADDLE_STEER_EN
  localparam logic [XW:0]          THIRD1  = (XW+1)'(PADDLE_W / 3);
  localparam logic [XW:0]          THIRD2  = (XW+1)'(2 * PADDLE_W / 3);
`endif

  logic signed [XW:0] dx, dx_m, x_ext;
  logic signed [YW:0] dy, dy_m, y_ext;
  logic [XW:0]        nx_e, px_e;
  logic               h_flip, v_flip, paddle_hit, death, fire;
  logic [XW-1:0]      mv_x;
  logic [YW-1:0]      mv_y;
  logic [2:0]         mv_dir;
  logic [19:0]        cnt, period_m1;
  logic               frozen;
`ifdef PADDLE_STEER_EN
  logic [XW:0]        off;
`endif

  function automatic logic [XW-1:0] clamp_x(input logic signed [XW:0] v);
    if (v[XW])                      return '0;
    else if (v[XW-1:0] > MAX_X_C)   return MAX_X_C;
    else                            return v[XW-1:0];
  endfunction

  function automatic logic [YW-1:0] clamp_y(input logic signed [YW:0] v);
    if (v[YW])                      return '0;
    else if (v[YW-1:0] > MAX_Y_C)   return MAX_Y_C;
    else                            return v[YW-1:0];
  endfunction

  // dy is never zero, so only its sign matters when re-encoding a direction
  function automatic logic [2:0] dir_code(input logic dx_neg, input logic dx_pos, input logic dy_neg);
    if (dy_neg) return dx_neg ? 3'd0 : (dx_pos ? 3'd2 : 3'd1);
    else        return dx_pos ? 3'd3 : (dx_neg ? 3'd5 : 3'd4);
  endfunction

  // decode direction, candidate cell, flips and the post-move position/direction
  always_comb begin
    dx = '0;
    dy = Y_NEG;
    case (dir)
      3'd0:    begin dx = X_NEG; dy = Y_NEG; end
      3'd1:    begin dx = '0;    dy = Y_NEG; end
      3'd2:    begin dx = X_ONE; dy = Y_NEG; end
      3'd3:    begin dx = X_ONE; dy = Y_ONE; end
      3'd4:    begin dx = '0;    dy = Y_ONE; end
      3'd5:    begin dx = X_NEG; dy = Y_ONE; end
      default: begin dx = '0;    dy = Y_NEG; end
    endcase

    x_ext  = signed'({1'b0, ball_x});
    y_ext  = signed'({1'b0, ball_y});
    next_x = clamp_x(x_ext + dx);
    next_y = clamp_y(y_ext + dy);

    nx_e = {1'b0, next_x};
    px_e = {1'b0, paddle_x};

    h_flip     = ((ball_x == '0) && dx[XW]) ||
                 ((ball_x == MAX_X_C) && !dx[XW] && (dx != '0));
    paddle_hit = !dy[YW] && (ball_y == PARK_Y) && (nx_e >= px_e) && (nx_e < px_e + PW);
    // wall, brick and paddle collapse into a single V-flip
    v_flip     = ((ball_y == '0) && dy[YW]) || brick_hit || paddle_hit;
    death      = (ball_y == MAX_Y_C) && !dy[YW];

    dx_m = h_flip ? -dx : dx;
    dy_m = v_flip ? -dy : dy;
`ifdef PADDLE_STEER_EN
    off = nx_e - px_e;
    if (paddle_hit) begin
      dy_m = Y_NEG;
      if (off < THIRD1)      dx_m = X_NEG;
      else if (off < THIRD2) dx_m = '0;
      else                   dx_m = X_ONE;
    end
`endif

    mv_x   = clamp_x(x_ext + dx_m);
    mv_y   = clamp_y(y_ext + dy_m);
    mv_dir = dir_code(dx_m[XW], !dx_m[XW] && (dx_m != '0), dy_m[YW]);

    period_m1 = (period == '0) ? '0 : period - 20'd1;
    fire      = (cnt >= period_m1);
  end

  // park / fly / hold sequencing with registered position, direction and pulses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ball_x <= '0;
      ball_y <= PARK_Y;
      dir    <= 3'd1;
      step   <= 1'b0;
      dead   <= 1'b0;
      cnt    <= '0;
      frozen <= 1'b0;
    end else begin
      step <= 1'b0;
      dead <= 1'b0;
      case (state)
        3'd0, 3'd1, 3'd2: begin
          ball_x <= paddle_x + HALF_W;
          ball_y <= PARK_Y;
          dir    <= (angle > 3'd5) ? 3'd1 : angle;
          cnt    <= '0;
          frozen <= 1'b0;
        end
        3'd3: begin
          if (frozen) begin
            cnt <= '0;
          end else if (fire) begin
            cnt <= '0;
            if (death) begin
              dead   <= 1'b1;
              frozen <= 1'b1;
            end else begin
              step   <= 1'b1;
              ball_x <= mv_x;
              ball_y <= mv_y;
              dir    <= mv_dir;
            end
          end else begin
            cnt <= cnt + 20'd1;
          end
        end
        default: begin
          cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ball_motion.sv
// tb/tb_ball_motion.sv - directed vector bench for ball_motion
module tb_ball_motion;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  state;
  logic [19:0] period;
  logic [2:0]  angle;
  logic [6:0]  paddle_x;
  logic        brick_hit;
  logic [6:0]  ball_x, next_x;
  logic [5:0]  ball_y, next_y;
  logic [2:0]  dir;
  logic        step, dead;

  int pass_cnt = 0;
  int total_cnt = 0;

  ball_motion dut (
    .clk(clk), .rst(rst), .state(state), .period(period), .angle(angle),
    .paddle_x(paddle_x), .brick_hit(brick_hit), .ball_x(ball_x), .ball_y(ball_y),
    .next_x(next_x), .next_y(next_y), .dir(dir), .step(step), .dead(dead)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  st;
    logic [19:0] per;
    logic [2:0]  ang;
    logic [6:0]  px;
    int          ex, ey, ed, es, edd;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic chk_all(input string tag, input int ex, input int ey, input int ed,
                         input int es, input int edd);
    chk({tag, ".x"},    int'(ball_x), ex);
    chk({tag, ".y"},    int'(ball_y), ey);
    chk({tag, ".dir"},  int'(dir),    ed);
    chk({tag, ".step"}, int'(step),   es);
    chk({tag, ".dead"}, int'(dead),   edd);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic park(input logic [6:0] px, input logic [2:0] ang);
    state = 3'd2; paddle_x = px; angle = ang;
    tick();
  endtask

  initial begin
    rst = 1'b0; state = 3'd0; period = 20'd0; angle = 3'd0;
    paddle_x = 7'd0; brick_hit = 1'b0;

    //             st   per ang  px    x   y  d  s  dead
    vecs[0]  = '{3'd2, 20'd0, 3'd2, 7'd10, 16, 55, 2, 0, 0};
    vecs[1]  = '{3'd0, 20'd0, 3'd5, 7'd0,   6, 55, 5, 0, 0};
    vecs[2]  = '{3'd1, 20'd0, 3'd7, 7'd20, 26, 55, 1, 0, 0};
    vecs[3]  = '{3'd2, 20'd0, 3'd6, 7'd67, 73, 55, 1, 0, 0};
    vecs[4]  = '{3'd4, 20'd0, 3'd3, 7'd0,  73, 55, 1, 0, 0};
    vecs[5]  = '{3'd2, 20'd0, 3'd0, 7'd40, 46, 55, 0, 0, 0};
    vecs[6]  = '{3'd3, 20'd2, 3'd0, 7'd40, 46, 55, 0, 0, 0};
    vecs[7]  = '{3'd3, 20'd2, 3'd0, 7'd40, 45, 54, 0, 1, 0};
    vecs[8]  = '{3'd3, 20'd2, 3'd0, 7'd40, 45, 54, 0, 0, 0};
    vecs[9]  = '{3'd4, 20'd2, 3'd0, 7'd40, 45, 54, 0, 0, 0};
    vecs[10] = '{3'd3, 20'd0, 3'd0, 7'd40, 44, 53, 0, 1, 0};
    vecs[11] = '{3'd3, 20'd1, 3'd0, 7'd40, 43, 52, 0, 1, 0};
    vecs[12] = '{3'd3, 20'd3, 3'd0, 7'd40, 43, 52, 0, 0, 0};
    vecs[13] = '{3'd4, 20'd3, 3'd0, 7'd40, 43, 52, 0, 0, 0};
    vecs[14] = '{3'd3, 20'd3, 3'd0, 7'd40, 43, 52, 0, 0, 0};
    vecs[15] = '{3'd3, 20'd3, 3'd0, 7'd40, 43, 52, 0, 0, 0};
    vecs[16] = '{3'd3, 20'd3, 3'd0, 7'd40, 42, 51, 0, 1, 0};

    @(negedge clk);
    chk_all("reset", 0, 55, 1, 0, 0);
    rst = 1'b1;

    for (int i = 0; i < 17; i++) begin
      state = vecs[i].st; period = vecs[i].per; angle = vecs[i].ang; paddle_x = vecs[i].px;
      tick();
      chk_all($sformatf("vec%0d", i), vecs[i].ex, vecs[i].ey, vecs[i].ed, vecs[i].es, vecs[i].edd);
    end

    // launch: first step on the 4th clock with period 4
    park(7'd10, 3'd2);
    chk_all("launch.park", 16, 55, 2, 0, 0);
    state = 3'd3; period = 20'd4;
    for (int i = 0; i < 3; i++) tick();
    chk_all("launch.wait", 16, 55, 2, 0, 0);
    tick();
    chk_all("launch.step", 17, 54, 2, 1, 0);

    // asynchronous reset mid-flight
    tick();
    rst = 1'b0;
    #1;
    chk_all("async_rst", 0, 55, 1, 0, 0);
    @(negedge clk);
    rst = 1'b1;

    // corner reflection at (0,0)
    park(7'd49, 3'd0);
    state = 3'd3; period = 20'd1;
    for (int i = 0; i < 55; i++) tick();
    chk_all("corner.pre", 0, 0, 0, 1, 0);
    tick();
    chk_all("corner.post", 1, 1, 3, 1, 0);

    // paddle hit, centre
    park(7'd34, 3'd4);
    state = 3'd3; paddle_x = 7'd35;
    tick();
    chk_all("paddle.mid", 40, 54, 1, 1, 0);

    // paddle hit near left edge
    park(7'd34, 3'd4);
    state = 3'd3; paddle_x = 7'd38;
    tick();
`ifdef PADDLE_STEER_EN
    chk_all("paddle.left", 39, 54, 0, 1, 0);
`else
    chk_all("paddle.left", 40, 54, 1, 1, 0);
`endif

    // paddle just right of the ball: miss
    park(7'd34, 3'd4);
    state = 3'd3; paddle_x = 7'd41;
    tick();
    chk_all("paddle.miss_r", 40, 56, 4, 1, 0);

    // paddle ending exactly at the ball column: miss
    park(7'd34, 3'd4);
    state = 3'd3; paddle_x = 7'd28;
    tick();
    chk_all("paddle.miss_l", 40, 56, 4, 1, 0);

    // paddle and brick together: a single V-flip
    park(7'd34, 3'd4);
    state = 3'd3; paddle_x = 7'd35; brick_hit = 1'b1;
    tick();
    brick_hit = 1'b0;
    chk_all("paddle_brick", 40, 54, 1, 1, 0);

    // brick at the right wall: both flips
    park(7'd67, 3'd2);
    state = 3'd3; period = 20'd1;
    for (int i = 0; i < 6; i++) tick();
    chk_all("brick.pre", 79, 49, 2, 1, 0);
    brick_hit = 1'b1;
    tick();
    brick_hit = 1'b0;
    chk_all("brick.wall", 78, 50, 5, 1, 0);

    // death at the bottom row
    park(7'd0, 3'd4);
    state = 3'd3; paddle_x = 7'd100;
    for (int i = 0; i < 4; i++) tick();
    chk_all("death.pre", 6, 59, 4, 1, 0);
    tick();
    chk_all("death.pulse", 6, 59, 4, 0, 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_all($sformatf("death.frozen%0d", i), 6, 59, 4, 0, 0);
    end
    park(7'd0, 3'd4);
    chk_all("death.repark", 6, 55, 4, 0, 0);
    state = 3'd3; paddle_x = 7'd100;
    for (int i = 0; i < 5; i++) tick();
    chk_all("death.again", 6, 59, 4, 0, 1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
